unidade_busca_pc: RTL and testbench
===================================

// Module: unidade_busca_pc
// PURPOSE
//  Fetch/sequencing stage directly upstream of the control unit. Holds the PC and
//  fetches 32-bit instructions from synchronous instruction ROM. Presents the latched
//  instruction and its 5-bit opcode to the decoder. Consumes the decoder's
//  controleDesvios, BreakFlag, FlagJumpReg and PrintFlag to choose the next PC,
//  halt, or stall for user input. Issues one commit pulse per instruction.
// PARAMETERS
//  ADDR_W  8   instruction address width; PC wraps modulo 2^ADDR_W
//  INSTR_W 32  instruction width; opcode = instrucao[INSTR_W-1 -: 5]
// PORTS
//  clock            in  1       single clock, rising edge
//  resetn           in  1       asynchronous, active-low reset
//  instrucaoMem     in  INSTR_W ROM data, valid 1 cycle after enderecoMem
//  controleDesvios  in  2       decoder: 00 seq, 01 branch-if-equal, 10 jump, 11 seq
//  condicaoULA      in  1       ALU compare result bit 0 (1 = equal)
//  BreakFlag        in  1       decoder: halt
//  FlagJumpReg      in  1       decoder: jump-and-link
//  PrintFlag        in  1       decoder: input instruction, wait for user
//  confirmaEntrada  in  1       user confirm, pre-synchronised level
//  enderecoMem      out ADDR_W  ROM address
//  instrucao        out INSTR_W latched instruction to decoder/datapath
//  opcode           out 5       instrucao[INSTR_W-1 -: 5]
//  pc               out ADDR_W  address of instruction in instrucao
//  habilitaExec     out 1       1-cycle commit pulse; gates reg/mem writes
//  escreveRetorno   out 1       1-cycle pulse with habilitaExec on JAL
//  enderecoRetorno  out ADDR_W  pc+1 of the JAL, held until next JAL
//  esperandoEntrada out 1       high while in ESPERA
//  parado           out 1       high while in PARADO
// BEHAVIOUR
//  Reset (async, immediate, also mid-instruction): state=BUSCA, pc=0, enderecoMem=0,
//   instrucao={5'b10000,0} (NOP), habilitaExec=0, escreveRetorno=0,
//   enderecoRetorno=0, esperandoEntrada=0, parado=0, edge register=0.
//  FSM: BUSCA -> CARGA -> EXEC; 3 cycles per instruction.
//   BUSCA: enderecoMem=pc. CARGA: instrucao<=instrucaoMem.
//   EXEC: decoder outputs settled combinationally from opcode; evaluate in priority order:
//    1 BreakFlag  -> PARADO; no habilitaExec; pc unchanged.
//    2 PrintFlag  -> ESPERA; no habilitaExec yet.
//    3 otherwise  -> habilitaExec=1, pc<=next, -> BUSCA.
//   next: 00/11 pc+1; 01 condicaoULA ? alvo : pc+1; 10 alvo;
//    alvo = instrucao[ADDR_W-1:0]. pc+1 wraps 2^ADDR_W-1 -> 0.
//   FlagJumpReg in EXEC: escreveRetorno=1, enderecoRetorno<=pc+1 (wrapped).
//  ESPERA: advances only on rising edge of confirmaEntrada (0 in previous cycle,
//   1 now). Level already high on entry: release then press required. On edge:
//   habilitaExec=1 for that cycle, pc<=pc+1, -> BUSCA.
//  PARADO: terminal until reset; pc, enderecoMem, instrucao frozen.
//  habilitaExec never high for two consecutive cycles; never high in BUSCA/CARGA.
// STRUCTURE
//  Shared package: state encoding (BUSCA, CARGA, EXEC, ESPERA, PARADO),
//   opcode constants (OP_NOP=5'b10000, OP_BREAK=5'b10100, OP_JAL=5'b10011,
//   OP_ENTRADA=5'b10110), desvio codes (DESV_SEQ=00, DESV_BEQ=01, DESV_JUMP=10).
//  One sub-module: detector_borda (rising-edge detect, async active-low reset).
// TESTING
//  1 Reset, ROM[0..1]=soma -> enderecoMem 0,0,0,1; habilitaExec pulses cycles 3,6.
//  2 ROM[2]=jump alvo=9 -> after EXEC pc=9, enderecoMem=9; no pulse on escreveRetorno.
//  3 ROM[4]=beq alvo=20: condicaoULA=1 -> pc=20; rerun condicaoULA=0 -> pc=5.
//  4 ROM[7]=jal alvo=30 -> escreveRetorno & habilitaExec same cycle,
//    enderecoRetorno=8, pc=30.
//  5 ROM[3]=entrada, confirmaEntrada high on entry -> esperandoEntrada=1, no
//    progress 50 cycles; drop then raise -> exactly one habilitaExec, pc=4.
//  6 ROM[6]=break -> parado=1, enderecoMem=6 for 100 cycles; separately
//    pc=255 seq -> pc=0; resetn low mid-ESPERA -> pc=0, outputs at reset values at once.

Source files
------------

// File: rtl/unidade_busca_pc_pkg.sv
// Shared constants for the fetch/sequencing stage: state encoding,
// opcodes the stage cares about and the decoder's branch-control codes.
package unidade_busca_pc_pkg;

    // FSM state encoding
    localparam logic [2:0] BUSCA  = 3'd0;
    localparam logic [2:0] CARGA  = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] ESPERA = 3'd3;
    localparam logic [2:0] PARADO = 3'd4;

    // Opcodes with special meaning to the fetch stage
    localparam logic [4:0] OP_NOP     = 5'b10000;
    localparam logic [4:0] OP_BREAK   = 5'b10100;
    localparam logic [4:0] OP_JAL     = 5'b10011;
    localparam logic [4:0] OP_ENTRADA = 5'b10110;

    // Branch-control codes coming from the decoder
    typedef logic [1:0] desvio_t;
    localparam desvio_t DESV_SEQ  = 2'b00;
    localparam desvio_t DESV_BEQ  = 2'b01;
    localparam desvio_t DESV_JUMP = 2'b10;

endpackage

// File: rtl/unidade_busca_pc_if.sv
// Bus between the fetch stage and its neighbours: instruction ROM,
// decoder/datapath and the user-input confirmation.
interface unidade_busca_pc_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    import unidade_busca_pc_pkg::*;

    logic [INSTR_W-1:0] instrucaoMem;
    desvio_t            controleDesvios;
    logic               condicaoULA;
    logic               BreakFlag;
    logic               FlagJumpReg;
    logic               PrintFlag;
    logic               confirmaEntrada;

    logic [ADDR_W-1:0]  enderecoMem;
    logic [INSTR_W-1:0] instrucao;
    logic [4:0]         opcode;
    logic [ADDR_W-1:0]  pc;
    logic               habilitaExec;
    logic               escreveRetorno;
    logic [ADDR_W-1:0]  enderecoRetorno;
    logic               esperandoEntrada;
    logic               parado;

    // Fetch stage side
    modport master (
        input  instrucaoMem, controleDesvios, condicaoULA, BreakFlag,
               FlagJumpReg, PrintFlag, confirmaEntrada,
        output enderecoMem, instrucao, opcode, pc, habilitaExec,
               escreveRetorno, enderecoRetorno, esperandoEntrada, parado
    );

    // ROM / decoder / user side
    modport slave (
        output instrucaoMem, controleDesvios, condicaoULA, BreakFlag,
               FlagJumpReg, PrintFlag, confirmaEntrada,
        input  enderecoMem, instrucao, opcode, pc, habilitaExec,
               escreveRetorno, enderecoRetorno, esperandoEntrada, parado
    );

endinterface

// File: rtl/unidade_busca_pc_detector_borda.sv
// Rising-edge detector for an already synchronised level: the pulse is
// high in the cycle where the input is 1 and was 0 in the previous cycle.
module detector_borda (
    input  logic clock,
    input  logic resetn,
    input  logic entrada,
    output logic borda
);

    logic anterior;

    // Remember last cycle's level so a level held high never re-triggers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) anterior <= 1'b0;
        else         anterior <= entrada;
    end

    assign borda = entrada & ~anterior;

endmodule

// File: rtl/unidade_busca_pc.sv
// Fetch/sequencing stage: holds the PC, fetches from synchronous ROM,
// latches the instruction for the decoder and chooses the next PC from
// the decoder's flags. Three cycles per instruction (BUSCA, CARGA, EXEC),
// with ESPERA for user input and PARADO as the terminal halt state.
module unidade_busca_pc
    import unidade_busca_pc_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic              clock,
    input  logic              resetn,
    unidade_busca_pc_if.master bus
);

    logic [2:0]         estado;
    logic [ADDR_W-1:0]  pcReg;
    logic [ADDR_W-1:0]  pcMais1;
    logic [ADDR_W-1:0]  alvo;
    logic [ADDR_W-1:0]  proximoPc;
    logic [ADDR_W-1:0]  retornoReg;
    logic [INSTR_W-1:0] instrucaoReg;
    logic               bordaConfirma;
    logic               commitExec;
    logic               commitEspera;

    detector_borda u_borda (
        .clock   (clock),
        .resetn  (resetn),
        .entrada (bus.confirmaEntrada),
        .borda   (bordaConfirma)
    );

    assign pcMais1 = pcReg + ADDR_W'(1);
    assign alvo    = instrucaoReg[ADDR_W-1:0];

    // Next-PC selection from the decoder's branch control
    always_comb begin
        proximoPc = pcMais1;
        case (bus.controleDesvios)
            DESV_BEQ:  if (bus.condicaoULA) proximoPc = alvo;
            DESV_JUMP: proximoPc = alvo;
            default:   proximoPc = pcMais1;
        endcase
    end

    // Commit happens in EXEC unless halting or waiting, or on a confirm edge in ESPERA
    assign commitExec   = (estado == EXEC) && !bus.BreakFlag && !bus.PrintFlag;
    assign commitEspera = (estado == ESPERA) && bordaConfirma;

    // Sequencer state, PC, instruction latch and return address
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado       <= BUSCA;
            pcReg        <= '0;
            retornoReg   <= '0;
            instrucaoReg <= {OP_NOP, {(INSTR_W-5){1'b0}}};
        end else begin
            case (estado)
                BUSCA: estado <= CARGA;
                CARGA: begin
                    instrucaoReg <= bus.instrucaoMem;
                    estado       <= EXEC;
                end
                EXEC: begin
                    if (bus.BreakFlag) begin
                        estado <= PARADO;
                    end else if (bus.PrintFlag) begin
                        estado <= ESPERA;
                    end else begin
                        pcReg  <= proximoPc;
                        estado <= BUSCA;
                        if (bus.FlagJumpReg) retornoReg <= pcMais1;
                    end
                end
                ESPERA: begin
                    if (bordaConfirma) begin
                        pcReg  <= pcMais1;
                        estado <= BUSCA;
                    end
                end
                PARADO:  estado <= PARADO;
                default: estado <= BUSCA;
            endcase
        end
    end

    assign bus.enderecoMem      = pcReg;
    assign bus.pc               = pcReg;
    assign bus.instrucao        = instrucaoReg;
    assign bus.opcode           = instrucaoReg[INSTR_W-1 -: 5];
    assign bus.habilitaExec     = commitExec | commitEspera;
    assign bus.escreveRetorno   = commitExec & bus.FlagJumpReg;
    assign bus.enderecoRetorno  = retornoReg;
    assign bus.esperandoEntrada = (estado == ESPERA);
    assign bus.parado           = (estado == PARADO);

endmodule

// File: tb/tb_unidade_busca_pc.sv
// Bench for unidade_busca_pc: small ROM and opcode decoder model around
// the fetch stage, single-instruction vector table plus directed sequences.
module tb_unidade_busca_pc;
    import unidade_busca_pc_pkg::*;

    localparam logic [4:0] OP_SOMA   = 5'b00000;
    localparam logic [4:0] OP_BEQ    = 5'b00001;
    localparam logic [4:0] OP_JUMP   = 5'b00010;
    localparam logic [4:0] OP_DESV11 = 5'b00011;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic [31:0] rom [0:255];

    int checks = 0;
    int errors = 0;

    unidade_busca_pc_if #(.ADDR_W(8), .INSTR_W(32)) busIf ();

    unidade_busca_pc #(.ADDR_W(8), .INSTR_W(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (busIf)
    );

    always #5 clock = ~clock;

    // Synchronous instruction ROM: data one cycle after the address
    always @(posedge clock) busIf.instrucaoMem <= rom[busIf.enderecoMem];

    // Decoder model: flags derived combinationally from the opcode
    always_comb begin
        busIf.controleDesvios = DESV_SEQ;
        busIf.BreakFlag       = 1'b0;
        busIf.FlagJumpReg     = 1'b0;
        busIf.PrintFlag       = 1'b0;
        case (busIf.opcode)
            OP_BEQ:     busIf.controleDesvios = DESV_BEQ;
            OP_JUMP:    busIf.controleDesvios = DESV_JUMP;
            OP_DESV11:  busIf.controleDesvios = 2'b11;
            OP_JAL: begin
                busIf.controleDesvios = DESV_JUMP;
                busIf.FlagJumpReg     = 1'b1;
            end
            OP_BREAK:   busIf.BreakFlag = 1'b1;
            OP_ENTRADA: busIf.PrintFlag = 1'b1;
            default:    busIf.controleDesvios = DESV_SEQ;
        endcase
    end

    typedef struct {
        logic [31:0] instr;
        logic        cond;
        logic        expHab;
        logic        expEscreve;
        logic [7:0]  expPc;
        logic [7:0]  expRet;
        logic        expEspera;
        logic        expParado;
    } vetor_t;

    vetor_t vetores [10];

    function automatic logic [31:0] instr(input logic [4:0] op, input logic [7:0] alvo);
        return {op, 19'd0, alvo};
    endfunction

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 32'd0;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    // After this returns the DUT is in its first BUSCA cycle (cycle 1)
    task automatic doReset();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
    endtask

    task automatic applyStimulus(input vetor_t v, input int idx);
        clearRom();
        rom[0] = v.instr;
        busIf.condicaoULA = v.cond;
        doReset();
        stepCycles(2);
        checkOutput($sformatf("vec%0d hab", idx), v.expHab, busIf.habilitaExec);
        checkOutput($sformatf("vec%0d escreve", idx), busIf.escreveRetorno, v.expEscreve);
        stepCycles(1);
        checkOutput($sformatf("vec%0d pc", idx), busIf.pc, v.expPc);
        checkOutput($sformatf("vec%0d ret", idx), busIf.enderecoRetorno, v.expRet);
        checkOutput($sformatf("vec%0d espera", idx), busIf.esperandoEntrada, v.expEspera);
        checkOutput($sformatf("vec%0d parado", idx), busIf.parado, v.expParado);
    endtask

    logic [31:0] expEnd [6];
    logic        expHabSeq [6];

    initial begin
        int pulsos;
        int violacoes;

        //                 instr                       cond hab esc pc     ret   esp par
        vetores[0] = '{instr(OP_SOMA, 8'd5),      1'b0, 1'b1, 1'b0, 8'd1,   8'd0, 1'b0, 1'b0};
        vetores[1] = '{instr(OP_JUMP, 8'd9),      1'b0, 1'b1, 1'b0, 8'd9,   8'd0, 1'b0, 1'b0};
        vetores[2] = '{instr(OP_BEQ, 8'd20),      1'b1, 1'b1, 1'b0, 8'd20,  8'd0, 1'b0, 1'b0};
        vetores[3] = '{instr(OP_BEQ, 8'd20),      1'b0, 1'b1, 1'b0, 8'd1,   8'd0, 1'b0, 1'b0};
        vetores[4] = '{instr(OP_JAL, 8'd30),      1'b0, 1'b1, 1'b1, 8'd30,  8'd1, 1'b0, 1'b0};
        vetores[5] = '{instr(OP_NOP, 8'd7),       1'b1, 1'b1, 1'b0, 8'd1,   8'd0, 1'b0, 1'b0};
        vetores[6] = '{instr(OP_DESV11, 8'd40),   1'b1, 1'b1, 1'b0, 8'd1,   8'd0, 1'b0, 1'b0};
        vetores[7] = '{instr(OP_ENTRADA, 8'd0),   1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b1, 1'b0};
        vetores[8] = '{instr(OP_BREAK, 8'd0),     1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b1};
        vetores[9] = '{instr(OP_JUMP, 8'd255),    1'b0, 1'b1, 1'b0, 8'd255, 8'd0, 1'b0, 1'b0};

        expEnd    = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
        expHabSeq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        busIf.condicaoULA     = 1'b0;
        busIf.confirmaEntrada = 1'b0;
        clearRom();

        // Reset state while resetn is held low
        #12;
        checkOutput("reset pc", busIf.pc, 32'd0);
        checkOutput("reset enderecoMem", busIf.enderecoMem, 32'd0);
        checkOutput("reset instrucao", busIf.instrucao, 32'h8000_0000);
        checkOutput("reset opcode", busIf.opcode, {27'd0, OP_NOP});
        checkOutput("reset hab", busIf.habilitaExec, 32'd0);
        checkOutput("reset escreve", busIf.escreveRetorno, 32'd0);
        checkOutput("reset ret", busIf.enderecoRetorno, 32'd0);
        checkOutput("reset espera", busIf.esperandoEntrada, 32'd0);
        checkOutput("reset parado", busIf.parado, 32'd0);

        // Single-instruction vectors
        for (int i = 0; i < 10; i++) applyStimulus(vetores[i], i);
        busIf.condicaoULA = 1'b0;

        // Sequential fetch timing, then jump from address 2
        clearRom();
        rom[2] = instr(OP_JUMP, 8'd9);
        doReset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) stepCycles(1);
            checkOutput($sformatf("seq c%0d enderecoMem", c + 1), busIf.enderecoMem, expEnd[c]);
            checkOutput($sformatf("seq c%0d hab", c + 1), busIf.habilitaExec, expHabSeq[c]);
        end
        stepCycles(3);
        checkOutput("jump hab", busIf.habilitaExec, 32'd1);
        checkOutput("jump escreve", busIf.escreveRetorno, 32'd0);
        stepCycles(1);
        checkOutput("jump pc", busIf.pc, 32'd9);
        checkOutput("jump enderecoMem", busIf.enderecoMem, 32'd9);

        // beq at address 4, taken and not taken
        clearRom();
        rom[0] = instr(OP_JUMP, 8'd4);
        rom[4] = instr(OP_BEQ, 8'd20);
        busIf.condicaoULA = 1'b1;
        doReset();
        stepCycles(6);
        checkOutput("beq taken pc", busIf.pc, 32'd20);
        busIf.condicaoULA = 1'b0;
        doReset();
        stepCycles(6);
        checkOutput("beq not taken pc", busIf.pc, 32'd5);

        // jal at address 7
        clearRom();
        rom[0] = instr(OP_JUMP, 8'd7);
        rom[7] = instr(OP_JAL, 8'd30);
        doReset();
        stepCycles(5);
        checkOutput("jal hab", busIf.habilitaExec, 32'd1);
        checkOutput("jal escreve", busIf.escreveRetorno, 32'd1);
        stepCycles(1);
        checkOutput("jal pc", busIf.pc, 32'd30);
        checkOutput("jal ret", busIf.enderecoRetorno, 32'd8);
        checkOutput("jal escreve after", busIf.escreveRetorno, 32'd0);

        // Input wait at address 3 with confirm already high on entry
        clearRom();
        rom[0] = instr(OP_JUMP, 8'd3);
        rom[3] = instr(OP_ENTRADA, 8'd0);
        busIf.confirmaEntrada = 1'b1;
        doReset();
        stepCycles(6);
        checkOutput("entrada espera", busIf.esperandoEntrada, 32'd1);
        pulsos = 0;
        for (int i = 0; i < 50; i++) begin
            stepCycles(1);
            if (busIf.habilitaExec) pulsos++;
        end
        checkOutput("entrada sem pulso", pulsos, 32'd0);
        checkOutput("entrada pc parado", busIf.pc, 32'd3);
        checkOutput("entrada ainda espera", busIf.esperandoEntrada, 32'd1);
        busIf.confirmaEntrada = 1'b0;
        stepCycles(1);
        busIf.confirmaEntrada = 1'b1;
        #1;
        pulsos = 0;
        if (busIf.habilitaExec) pulsos++;
        checkOutput("entrada pulso", busIf.habilitaExec, 32'd1);
        stepCycles(1);
        if (busIf.habilitaExec) pulsos++;
        checkOutput("entrada pc", busIf.pc, 32'd4);
        checkOutput("entrada saiu", busIf.esperandoEntrada, 32'd0);
        stepCycles(1);
        if (busIf.habilitaExec) pulsos++;
        checkOutput("entrada um pulso", pulsos, 32'd1);
        busIf.confirmaEntrada = 1'b0;

        // Break at address 6 freezes everything
        clearRom();
        rom[0] = instr(OP_JUMP, 8'd6);
        rom[6] = instr(OP_BREAK, 8'd0);
        doReset();
        stepCycles(6);
        checkOutput("break parado", busIf.parado, 32'd1);
        violacoes = 0;
        for (int i = 0; i < 100; i++) begin
            stepCycles(1);
            if (!busIf.parado || busIf.enderecoMem !== 8'd6 || busIf.habilitaExec
                || busIf.instrucao !== instr(OP_BREAK, 8'd0)) violacoes++;
        end
        checkOutput("break congelado", violacoes, 32'd0);
        checkOutput("break pc", busIf.pc, 32'd6);

        // PC wrap from 255
        clearRom();
        rom[0]   = instr(OP_JUMP, 8'd255);
        rom[255] = instr(OP_SOMA, 8'd0);
        doReset();
        stepCycles(6);
        checkOutput("wrap pc", busIf.pc, 32'd0);

        // Asynchronous reset in the middle of ESPERA
        clearRom();
        rom[0] = instr(OP_JAL, 8'd3);
        rom[3] = instr(OP_ENTRADA, 8'd0);
        doReset();
        stepCycles(6);
        checkOutput("meio espera", busIf.esperandoEntrada, 32'd1);
        checkOutput("meio ret", busIf.enderecoRetorno, 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("async pc", busIf.pc, 32'd0);
        checkOutput("async enderecoMem", busIf.enderecoMem, 32'd0);
        checkOutput("async instrucao", busIf.instrucao, 32'h8000_0000);
        checkOutput("async espera", busIf.esperandoEntrada, 32'd0);
        checkOutput("async ret", busIf.enderecoRetorno, 32'd0);
        checkOutput("async hab", busIf.habilitaExec, 32'd0);
        stepCycles(2);
        resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
